// File: rtl/program_loader_pkg.sv
// Shared constants and types for the program loader and processor core.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         PM_DEPTH_DEF  = 64;
    localparam int         INSTR_W       = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_CHECK = 3'd4
    } ldr_state_t;

endpackage

// File: rtl/program_loader_checksum.sv
// 8-bit wrap-around accumulator; clear has priority over enable.
module loader_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] sum
);

    // Running sum of accepted data bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 8'd0;
        end else if (clear) begin
            sum <= 8'd0;
        end else if (enable) begin
            sum <= sum + data_in;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: receives a framed byte stream and writes 13-bit
// instruction words into program memory while holding the core in reset.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for the sync byte, other bytes dropped
// ST_COUNT | next byte is the word count N
// ST_LO    | next byte is the low 8 bits of a word
// ST_HI    | next byte is the high 5 bits of a word (bits 7:5 must be 0)
// ST_CHECK | next byte is the checksum of all data bytes
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         PM_DEPTH  = PM_DEPTH_DEF,
    localparam int        ADDR_W    = $clog2(PM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               abort,
    output logic               pm_we,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic [INSTR_W-1:0] pm_wdata,
    output logic               core_hold,
    output logic               done,
    output logic               error
);

    // Counter is one bit wider than the address so it can hold N = PM_DEPTH.
    localparam int CNT_W = ADDR_W + 1;

    ldr_state_t state, state_next;

    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] cnt_inc;
    logic [7:0]       lo_byte;
    logic [7:0]       cs_sum;
    logic [31:0]      n_ext;

    logic accept;
    logic cs_clear;
    logic cs_en;
    logic load_count;
    logic store_lo;
    logic write_word;
    logic set_done;
    logic set_error;
    logic clear_flags;

    assign rx_ready = 1'b1;
    assign accept   = rx_valid;
    assign cnt_inc  = word_cnt + CNT_W'(1);
    assign n_ext    = {24'd0, rx_data};

    loader_checksum u_checksum (
        .clk     (clk),
        .rst     (rst),
        .clear   (cs_clear),
        .enable  (cs_en),
        .data_in (rx_data),
        .sum     (cs_sum)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-byte control strobes; abort overrides everything.
    always_comb begin
        state_next  = state;
        cs_clear    = 1'b0;
        cs_en       = 1'b0;
        load_count  = 1'b0;
        store_lo    = 1'b0;
        write_word  = 1'b0;
        set_done    = 1'b0;
        set_error   = 1'b0;
        clear_flags = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_next  = ST_COUNT;
                    clear_flags = 1'b1;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    if (rx_data == 8'd0 || n_ext > PM_DEPTH) begin
                        state_next = ST_IDLE;
                        set_error  = 1'b1;
                    end else begin
                        state_next = ST_LO;
                        load_count = 1'b1;
                        cs_clear   = 1'b1;
                    end
                end
            end
            ST_LO: begin
                if (accept) begin
                    state_next = ST_HI;
                    store_lo   = 1'b1;
                    cs_en      = 1'b1;
                end
            end
            ST_HI: begin
                if (accept) begin
                    if (rx_data[7:5] != 3'b000) begin
                        state_next = ST_IDLE;
                        set_error  = 1'b1;
                    end else begin
                        cs_en      = 1'b1;
                        write_word = 1'b1;
                        state_next = (cnt_inc == count_n) ? ST_CHECK : ST_LO;
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_next = ST_IDLE;
                    if (rx_data == cs_sum) begin
                        set_done = 1'b1;
                    end else begin
                        set_error = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort && state != ST_IDLE) begin
            state_next  = ST_IDLE;
            set_error   = 1'b1;
            set_done    = 1'b0;
            write_word  = 1'b0;
            cs_en       = 1'b0;
            cs_clear    = 1'b0;
            store_lo    = 1'b0;
            load_count  = 1'b0;
            clear_flags = 1'b0;
        end
    end

    // Frame datapath: word count, low byte latch and word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_n  <= '0;
            word_cnt <= '0;
            lo_byte  <= 8'd0;
        end else begin
            if (load_count) begin
                count_n  <= rx_data[CNT_W-1:0];
                word_cnt <= '0;
            end else if (write_word) begin
                word_cnt <= cnt_inc;
            end
            if (store_lo) begin
                lo_byte <= rx_data;
            end
        end
    end

    // Program memory write port, registered one cycle after the high byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm_we    <= 1'b0;
            pm_addr  <= '0;
            pm_wdata <= '0;
        end else begin
            pm_we <= write_word;
            if (write_word) begin
                pm_addr  <= word_cnt[ADDR_W-1:0];
                pm_wdata <= {rx_data[4:0], lo_byte};
            end
        end
    end

    // Sticky status flags and core hold; the core runs whenever we are idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
        end else begin
            if (clear_flags) begin
                done  <= 1'b0;
                error <= 1'b0;
            end else begin
                if (set_done) begin
                    done <= 1'b1;
                end
                if (set_error) begin
                    error <= 1'b1;
                end
            end
            core_hold <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed frame vectors plus hand-written multi-cycle sequences.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        abort;
    logic        pm_we;
    logic [5:0]  pm_addr;
    logic [12:0] pm_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int checks;
    int errors;

    logic [18:0] wq[$];

    typedef struct {
        int              len;
        logic [0:7][7:0] b;
        int              sync_at;
        int              n_wr;
        logic [12:0]     w0;
        logic [12:0]     w1;
        logic            exp_done;
        logic            exp_error;
    } vec_t;

    vec_t vecs[7];

    program_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .abort     (abort),
        .pm_we     (pm_we),
        .pm_addr   (pm_addr),
        .pm_wdata  (pm_wdata),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe mid-cycle.
    always @(negedge clk) begin
        if (pm_we === 1'b1) wq.push_back({pm_addr, pm_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ab);
        rx_data  = b;
        rx_valid = 1'b1;
        abort    = ab;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        abort    = 1'b0;

        vecs[0] = '{7, {8'hA5,8'h02,8'h34,8'h12,8'hFF,8'h1F,8'h64,8'h00}, 0, 2, 13'h1234, 13'h1FFF, 1'b1, 1'b0};
        vecs[1] = '{5, {8'hA5,8'h01,8'h01,8'h00,8'h02,8'h00,8'h00,8'h00}, 0, 1, 13'h0001, 13'h0000, 1'b0, 1'b1};
        vecs[2] = '{2, {8'hA5,8'h41,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 13'h0000, 13'h0000, 1'b0, 1'b1};
        vecs[3] = '{2, {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 13'h0000, 13'h0000, 1'b0, 1'b1};
        vecs[4] = '{4, {8'hA5,8'h01,8'h00,8'h20,8'h00,8'h00,8'h00,8'h00}, 0, 0, 13'h0000, 13'h0000, 1'b0, 1'b1};
        vecs[5] = '{6, {8'h3C,8'hA5,8'h01,8'hA5,8'h00,8'hA5,8'h00,8'h00}, 1, 1, 13'h00A5, 13'h0000, 1'b1, 1'b0};
        vecs[6] = '{5, {8'hA5,8'h01,8'hFF,8'h1F,8'h1E,8'h00,8'h00,8'h00}, 0, 1, 13'h1FFF, 13'h0000, 1'b1, 1'b0};

        // Reset values while reset is held.
        #1;
        chk("rst_pm_we",     {31'd0, pm_we},     32'd0);
        chk("rst_pm_addr",   {26'd0, pm_addr},   32'd0);
        chk("rst_pm_wdata",  {19'd0, pm_wdata},  32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_error",     {31'd0, error},     32'd0);
        chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
        chk("rst_rx_ready",  {31'd0, rx_ready},  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("hold_after_rel", {31'd0, core_hold}, 32'd1);
        idle_cycle();
        chk("hold_first_edge", {31'd0, core_hold}, 32'd0);

        // Table-driven frames.
        for (int v = 0; v < 7; v++) begin
            wq.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                send_byte(vecs[v].b[i], 1'b0);
                chk($sformatf("v%0d_rx_ready", v), {31'd0, rx_ready}, 32'd1);
                if (i == vecs[v].sync_at) begin
                    chk($sformatf("v%0d_sync_done_clr", v), {31'd0, done}, 32'd0);
                    chk($sformatf("v%0d_sync_err_clr", v), {31'd0, error}, 32'd0);
                end
                if (i >= vecs[v].sync_at && i < vecs[v].len - 1)
                    chk($sformatf("v%0d_hold_b%0d", v, i), {31'd0, core_hold}, 32'd1);
            end
            chk($sformatf("v%0d_done", v),  {31'd0, done},      {31'd0, vecs[v].exp_done});
            chk($sformatf("v%0d_error", v), {31'd0, error},     {31'd0, vecs[v].exp_error});
            chk($sformatf("v%0d_hold", v),  {31'd0, core_hold}, 32'd0);
            idle_cycle();
            chk($sformatf("v%0d_nwr", v), wq.size(), vecs[v].n_wr);
            if (vecs[v].n_wr >= 1 && wq.size() >= 1)
                chk($sformatf("v%0d_wr0", v), {13'd0, wq[0]}, {13'd0, 6'd0, vecs[v].w0});
            if (vecs[v].n_wr >= 2 && wq.size() >= 2)
                chk($sformatf("v%0d_wr1", v), {13'd0, wq[1]}, {13'd0, 6'd1, vecs[v].w1});
        end

        // Full-depth frame: 64 words of 13'h1FFF, checksum 64*(FF+1F) mod 256 = 80.
        wq.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h40, 1'b0);
        for (int i = 0; i < 64; i++) begin
            send_byte(8'hFF, 1'b0);
            send_byte(8'h1F, 1'b0);
        end
        chk("full_hold_pre_cs", {31'd0, core_hold}, 32'd1);
        send_byte(8'h80, 1'b0);
        chk("full_done",  {31'd0, done},      32'd1);
        chk("full_error", {31'd0, error},     32'd0);
        chk("full_hold",  {31'd0, core_hold}, 32'd0);
        idle_cycle();
        chk("full_nwr", wq.size(), 64);
        for (int i = 0; i < 64; i++) begin
            if (i < wq.size())
                chk($sformatf("full_wr%0d", i), {13'd0, wq[i]}, {13'd0, 6'(i), 13'h1FFF});
        end

        // Abort while idle changes nothing.
        send_byte(8'h00, 1'b1);
        chk("idle_abort_err",  {31'd0, error}, 32'd0);
        chk("idle_abort_done", {31'd0, done},  32'd1);

        // Abort together with the high byte of word 0.
        wq.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b1);
        chk("abort_error", {31'd0, error},     32'd1);
        chk("abort_done",  {31'd0, done},      32'd0);
        chk("abort_hold",  {31'd0, core_hold}, 32'd0);
        idle_cycle();
        idle_cycle();
        chk("abort_nwr", wq.size(), 0);
        // Loader is back in IDLE: a data byte must not start anything.
        send_byte(8'h12, 1'b0);
        chk("abort_idle_hold", {31'd0, core_hold}, 32'd0);

        // Reset in the middle of a frame.
        wq.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h56, 1'b0);
        chk("mid_wr_before", wq.size(), 1);
        wq.delete();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_pm_we",  {31'd0, pm_we},     32'd0);
        chk("mid_rst_addr",   {26'd0, pm_addr},   32'd0);
        chk("mid_rst_wdata",  {19'd0, pm_wdata},  32'd0);
        chk("mid_rst_done",   {31'd0, done},      32'd0);
        chk("mid_rst_error",  {31'd0, error},     32'd0);
        chk("mid_rst_hold",   {31'd0, core_hold}, 32'd1);
        #4;
        rst = 1'b0;
        #1;
        chk("mid_rel_hold", {31'd0, core_hold}, 32'd1);
        send_byte(8'h78, 1'b0);
        send_byte(8'h1A, 1'b0);
        send_byte(8'h00, 1'b0);
        idle_cycle();
        chk("mid_after_nwr",  wq.size(), 0);
        chk("mid_after_hold", {31'd0, core_hold}, 32'd0);
        chk("mid_after_err",  {31'd0, error},     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
